// File: rtl/slug_pkg.sv
// slug_pkg: shared widths and ALU function codes for the slug execution stage.
package slug_pkg;
    localparam int PC_W_DEF  = 16;
    localparam int SEL_W_DEF = 3;
    localparam logic [3:0] ALU_ADD    = 4'h9;
    localparam logic [3:0] ALU_SUB    = 4'h6;
    localparam logic [3:0] ALU_PASS_A = 4'hF;
    localparam logic [3:0] ALU_PASS_B = 4'hA;
    localparam logic [3:0] ALU_ZERO   = 4'h3;
endpackage

// File: rtl/slug_exec_unit_alu181.sv
// alu181: 74181-style 4-bit ALU with active-high carry and a zero flag.
module alu181
    import slug_pkg::*;
(
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    output logic       cout,
    output logic       zero
);
    logic [3:0] t1, t2;
    logic [4:0] sum;
    // Logic mode is the XNOR of the two terms; arithmetic mode adds them.
    assign t1   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign t2   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    assign sum  = {1'b0, t1} + {1'b0, t2} + {4'b0, cin};
    assign f    = m ? ~(t1 ^ t2) : sum[3:0];
    assign cout = m ? 1'b0 : sum[4];
    assign zero = ~|f;
endmodule

// File: rtl/slug_exec_unit.sv
// slug_exec_unit: stage-4 ALU, program counter and bank select decoder.
module slug_exec_unit
    import slug_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_pc,
    input  logic                  inc_pc,
    input  logic [PC_W-1:0]       pc_x,
    output logic [PC_W-1:0]       pc,
    input  logic [3:0]            alu_s,
    input  logic                  alu_m,
    input  logic                  alu_cin,
    input  logic [3:0]            alu_a,
    input  logic [3:0]            alu_b,
    output logic [3:0]            alu_f,
    output logic                  alu_cout,
    output logic                  alu_zero,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   sel_oh
);
    // Load wins over increment; increment wraps naturally at the PC width.
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            pc <= '0;
        else if (ld_pc)
            pc <= pc_x;
        else if (inc_pc)
            pc <= pc + 1'b1;

    alu181 u_alu (
        .s   (alu_s),
        .m   (alu_m),
        .cin (alu_cin),
        .a   (alu_a),
        .b   (alu_b),
        .f   (alu_f),
        .cout(alu_cout),
        .zero(alu_zero)
    );

    assign sel_oh = {{(2**SEL_W-1){1'b0}}, 1'b1} << sel;
endmodule

// File: tb/tb_slug_exec_unit.sv
// tb_slug_exec_unit: directed and randomized checks of PC, ALU and decoder.
module tb_slug_exec_unit;
    import slug_pkg::*;

    logic        clk = 0, rst = 0, ld_pc = 0, inc_pc = 0;
    logic [15:0] pc_x = '0, pc;
    logic [3:0]  alu_s = '0, alu_a = '0, alu_b = '0, alu_f;
    logic        alu_m = 0, alu_cin = 0, alu_cout, alu_zero;
    logic [2:0]  sel = '0;
    logic [7:0]  sel_oh;
    int          n_assert = 0, n_fail = 0;
    logic [15:0] pc_m;

    slug_exec_unit dut (
        .clk(clk), .rst(rst), .ld_pc(ld_pc), .inc_pc(inc_pc), .pc_x(pc_x), .pc(pc),
        .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .sel(sel), .sel_oh(sel_oh)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Function tables as listed for the part; returns {cout, f}.
    function automatic logic [4:0] alu_ref(input logic [3:0] s, input logic m, input logic cin,
                                           input logic [3:0] a, input logic [3:0] b);
        logic [3:0] lf, x, y;
        lf = '0; x = '0; y = '0;
        case (s)
            4'd0:  begin lf = ~a;        x = a;        y = 4'd0;     end
            4'd1:  begin lf = ~(a | b);  x = a | b;    y = 4'd0;     end
            4'd2:  begin lf = ~a & b;    x = a | ~b;   y = 4'd0;     end
            4'd3:  begin lf = 4'd0;      x = 4'hF;     y = 4'd0;     end
            4'd4:  begin lf = ~(a & b);  x = a;        y = a & ~b;   end
            4'd5:  begin lf = ~b;        x = a | b;    y = a & ~b;   end
            4'd6:  begin lf = a ^ b;     x = a;        y = ~b;       end
            4'd7:  begin lf = a & ~b;    x = a & ~b;   y = 4'hF;     end
            4'd8:  begin lf = ~a | b;    x = a;        y = a & b;    end
            4'd9:  begin lf = ~(a ^ b);  x = a;        y = b;        end
            4'd10: begin lf = b;         x = a | ~b;   y = a & b;    end
            4'd11: begin lf = a & b;     x = a & b;    y = 4'hF;     end
            4'd12: begin lf = 4'hF;      x = a;        y = a;        end
            4'd13: begin lf = a | ~b;    x = a | b;    y = a;        end
            4'd14: begin lf = a | b;     x = a | ~b;   y = a;        end
            default: begin lf = a;       x = a;        y = 4'hF;     end
        endcase
        return m ? {1'b0, lf} : ({1'b0, x} + {1'b0, y} + {4'd0, cin});
    endfunction

    task automatic alu(input string tag, input logic [3:0] s, input logic m, input logic cin,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ef, input logic ec, input logic ez);
        alu_s = s; alu_m = m; alu_cin = cin; alu_a = a; alu_b = b;
        #1;
        chk({tag, "_f"}, 32'(alu_f), 32'(ef));
        chk({tag, "_cout"}, 32'(alu_cout), 32'(ec));
        chk({tag, "_zero"}, 32'(alu_zero), 32'(ez));
    endtask

    task automatic step(input logic l, input logic i, input logic [15:0] x);
        ld_pc = l; inc_pc = i; pc_x = x;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0] r;
        #12;
        chk("pc_reset_hold", 32'(pc), 32'h0);
        rst = 1;
        step(0, 1, 16'h0);
        step(0, 1, 16'h0);
        step(0, 1, 16'h0);
        chk("pc_inc3", 32'(pc), 32'h0003);
        step(1, 1, 16'hBEEF);
        chk("pc_ld_priority", 32'(pc), 32'hBEEF);
        step(1, 0, 16'hFFFF);
        chk("pc_ld_ffff", 32'(pc), 32'hFFFF);
        step(0, 1, 16'h0);
        chk("pc_wrap", 32'(pc), 32'h0000);
        step(1, 0, 16'h1234);
        step(0, 0, 16'h5555);
        step(0, 0, 16'h5555);
        chk("pc_hold", 32'(pc), 32'h1234);
        #2 rst = 0;
        #1 chk("pc_async_reset", 32'(pc), 32'h0);
        @(posedge clk); #1;
        chk("pc_reset_held_edge", 32'(pc), 32'h0);
        #4 rst = 1;
        pc_m = '0;
        for (int k = 0; k < 300; k++) begin
            logic l, i;
            logic [15:0] x;
            l = ($urandom_range(0, 3) == 0);
            i = 1'($urandom);
            x = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
            step(l, i, x);
            pc_m = l ? x : (i ? pc_m + 16'd1 : pc_m);
            chk("pc_random", 32'(pc), 32'(pc_m));
        end
        ld_pc = 0; inc_pc = 0;

        alu("add_7_9", ALU_ADD, 0, 0, 4'h7, 4'h9, 4'h0, 1, 1);
        alu("add_3_4", ALU_ADD, 0, 0, 4'h3, 4'h4, 4'h7, 0, 0);
        alu("sub_5_3", ALU_SUB, 0, 1, 4'h5, 4'h3, 4'h2, 1, 0);
        alu("sub_3_5", ALU_SUB, 0, 1, 4'h3, 4'h5, 4'hE, 0, 0);
        alu("log_xor", 4'h6, 1, 1, 4'hA, 4'hC, 4'h6, 0, 0);
        alu("log_and", 4'hB, 1, 0, 4'hA, 4'hC, 4'h8, 0, 0);
        alu("log_zero", ALU_ZERO, 1, 1, 4'hA, 4'hC, 4'h0, 0, 1);
        alu("pass_a", ALU_PASS_A, 1, 0, 4'h5, 4'hC, 4'h5, 0, 0);
        alu("pass_b", ALU_PASS_B, 1, 0, 4'h5, 4'hC, 4'hC, 0, 0);

        for (int m = 0; m < 2; m++)
            for (int s = 0; s < 16; s++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        for (int c = 0; c < 2; c++) begin
                            alu_m = 1'(m); alu_s = 4'(s); alu_a = 4'(a); alu_b = 4'(b); alu_cin = 1'(c);
                            #1;
                            r = alu_ref(4'(s), 1'(m), 1'(c), 4'(a), 4'(b));
                            chk("sweep_cout_f", {27'd0, alu_cout, alu_f}, {27'd0, r});
                            chk("sweep_zero", 32'(alu_zero), 32'(r[3:0] == 4'd0));
                        end

        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1 chk("decode", 32'(sel_oh), 32'(8'd1 << i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
